sr_using_t_ff: RTL and testbench



---
 rtl/sr_using_t_ff.sv | 57 +++++
 tb/tb_sr_using_t_ff.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sr_using_t_ff.sv
// Multi-lane SR flip-flop built from a T flip-flop plus excitation logic (T = S.Q' + R.Q).
// Define SR_USING_T_ERR_EN to add the registered per-lane invalid-input (s=r=1) flag on err.
module sr_using_t_ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
`ifdef SR_USING_T_ERR_EN
    output logic [WIDTH-1:0] err,
`endif
    output logic [WIDTH-1:0] qb
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] t;

    // s=r=1 leaves both terms false, so the T input stays low and the lane holds.
    always_comb begin
        t   = (s & ~r & ~q_q) | (r & ~s & q_q);
        q_d = q_q ^ t;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qb = ~q_q;

`ifdef SR_USING_T_ERR_EN
    logic [WIDTH-1:0] err_q;
    logic [WIDTH-1:0] err_d;

    always_comb begin
        err_d = s & r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_sr_using_t_ff.sv
// Scoreboard bench for sr_using_t_ff at WIDTH=4; expected q/err are pushed when s/r are driven
// and popped after the sampling edge.
module tb_sr_using_t_ff;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] err;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic [W-1:0] q;
    logic [W-1:0] qb;
`ifdef SR_USING_T_ERR_EN
    logic [W-1:0] err;
`endif

    exp_t         sb[$];
    logic [W-1:0] mdl_q;
    int           n_checks;
    int           n_pass;

    sr_using_t_ff #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .s   (s),
        .r   (r),
        .q   (q),
`ifdef SR_USING_T_ERR_EN
        .err (err),
`endif
        .qb  (qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one sample, predict from the SR truth table, then compare after the edge.
    task automatic apply(input string tag, input logic rr, input logic [W-1:0] ss,
                         input logic [W-1:0] rs);
        exp_t e;
        exp_t got_e;
        // Inputs wiggle mid-cycle first; only the value held at the edge may count.
        rst = rr;
        s   = ~ss;
        r   = ~rs;
        #1;
        s = ss;
        r = rs;
        if (rr) begin
            mdl_q = '0;
            e.err = '0;
        end else begin
            mdl_q = (mdl_q | (ss & ~rs)) & ~(rs & ~ss);
            e.err = ss & rs;
        end
        e.q = mdl_q;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            got_e = sb.pop_front();
            check({tag, "_q"}, {28'd0, q}, {28'd0, got_e.q});
            check({tag, "_qb"}, {28'd0, qb}, {28'd0, ~got_e.q});
`ifdef SR_USING_T_ERR_EN
            check({tag, "_err"}, {28'd0, err}, {28'd0, got_e.err});
`endif
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mdl_q    = '0;
        rst      = 1'b1;
        s        = '0;
        r        = '0;
        @(posedge clk);
        #1;

        apply("rst_beats_set0", 1'b1, 4'hF, 4'h0);
        apply("rst_beats_set1", 1'b1, 4'hF, 4'h0);
        apply("hold", 1'b0, 4'h0, 4'h0);
        apply("set0", 1'b0, 4'hF, 4'h0);
        apply("set1", 1'b0, 4'hF, 4'h0);
        apply("invalid_hold1", 1'b0, 4'hF, 4'hF);
        apply("err_clear", 1'b0, 4'h0, 4'h0);
        apply("rreq0", 1'b0, 4'h0, 4'hF);
        apply("rreq1", 1'b0, 4'h0, 4'hF);
        apply("invalid_hold0", 1'b0, 4'hF, 4'hF);
        apply("lane_set", 1'b0, 4'b0101, 4'b0010);
        apply("lane_rst", 1'b0, 4'b0000, 4'b0001);
        apply("lane_mix", 1'b0, 4'b1010, 4'b1001);
        apply("mid_rst", 1'b1, 4'hF, 4'h0);
        apply("post_rst_set", 1'b0, 4'b0011, 4'b0000);

        for (int i = 0; i < 40; i++) begin
            apply("rand", ($urandom_range(0, 9) == 0), W'($urandom), W'($urandom));
        end

        check("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
